// File: rtl/adc_capture_ctrl.sv
// Capture/drain sequencer for the ADC sample FIFO: fills the FIFO with a
// programmed number of samples, then hands words out one at a time over valid/ready.
module adc_capture_ctrl #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_samples_i,
    input  logic             adc_ready_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    input  logic             out_ready_i,
    output logic             wr_en_o,
    output logic             rd_en_o,
    output logic             fifo_rst_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, CAPTURE, RD, RWAIT, PRESENT, DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len, remaining, count, count_inc;
    logic             sample_hit, start_ok, abort_ok, leave_capture;
    logic             abort_rst_q, done_q, overflow_q;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] n);
        return (n > DEPTH_C) ? DEPTH_C : n;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_en_o    = 1'b0;
        rd_en_o    = 1'b0;
        start_ok   = (state == IDLE) && start_i;
        abort_ok   = (state != IDLE) && abort_i;
        count_inc  = count + ONE_C;
        sample_hit = (state == CAPTURE) && adc_ready_i && !fifo_full_i && !abort_i;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (n_samples_i == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: state_nxt = CAPTURE;
            CAPTURE: begin
                wr_en_o = 1'b1;
                if (fifo_full_i) begin
                    state_nxt = RD;
                end else if (adc_ready_i && (count_inc == len)) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                // remaining==0 covers a FIFO that reported full before any sample landed
                if (fifo_empty_i || (remaining == '0)) begin
                    state_nxt = DONE;
                end else begin
                    rd_en_o   = 1'b1;
                    state_nxt = RWAIT;
                end
            end
            RWAIT: state_nxt = PRESENT;
            PRESENT: begin
                if (out_ready_i) begin
                    state_nxt = (remaining == ONE_C) ? DONE : RD;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_ok) begin
            state_nxt = IDLE;
            wr_en_o   = 1'b0;
            rd_en_o   = 1'b0;
        end
        leave_capture = (state == CAPTURE) && (state_nxt == RD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count       <= '0;
            overflow_q  <= 1'b0;
            abort_rst_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            abort_rst_q <= abort_ok;
            done_q      <= (state == DONE) && !abort_i;
            if (start_ok) begin
                count      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (sample_hit) begin
                    count <= count_inc;
                end
                if (leave_capture && fifo_full_i) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Length and drain counter only matter once a run is underway
    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            len <= clamp_len(n_samples_i);
        end
        if (leave_capture) begin
            remaining <= sample_hit ? count_inc : count;
        end else if ((state == PRESENT) && out_ready_i && !abort_i) begin
            remaining <= remaining - ONE_C;
        end
    end

    assign fifo_rst_o = (state == CLEAR) || abort_rst_q;
    assign valid_o    = (state == PRESENT);
    assign busy_o     = (state != IDLE);
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign count_o    = count;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a small occupancy model of the FIFO.
module tb_adc_capture_ctrl;
    localparam int CNT_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic             adc_ready_i = 1'b0, out_ready_i = 1'b1, force_full = 1'b0;
    logic [CNT_W-1:0] n_samples_i = '0;
    logic             fifo_full_i, fifo_empty_i;
    logic             wr_en_o, rd_en_o, fifo_rst_o, valid_o, busy_o, done_o, overflow_o;
    logic [CNT_W-1:0] count_o;

    int occ = 0, n_wr = 0, n_rd = 0, n_hs = 0, n_done = 0, n_frst = 0;
    int b_wr, b_rd, b_hs, b_done, b_frst;
    int checks = 0, errors = 0;

    adc_capture_ctrl #(.DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .n_samples_i(n_samples_i), .adc_ready_i(adc_ready_i),
        .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
        .out_ready_i(out_ready_i), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
        .fifo_rst_o(fifo_rst_o), .valid_o(valid_o), .busy_o(busy_o),
        .done_o(done_o), .overflow_o(overflow_o), .count_o(count_o)
    );

    assign fifo_full_i  = force_full || (occ >= 1024);
    assign fifo_empty_i = (occ == 0);

    always @(posedge clk) begin
        if (rst_i || fifo_rst_o) occ <= 0;
        else occ <= occ + ((wr_en_o && adc_ready_i && !fifo_full_i) ? 1 : 0) - (rd_en_o ? 1 : 0);
        if (wr_en_o && adc_ready_i && !fifo_full_i) n_wr <= n_wr + 1;
        if (rd_en_o) n_rd <= n_rd + 1;
        if (valid_o && out_ready_i) n_hs <= n_hs + 1;
        if (done_o) n_done <= n_done + 1;
        if (fifo_rst_o) n_frst <= n_frst + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task snap;
        b_wr = n_wr; b_rd = n_rd; b_hs = n_hs; b_done = n_done; b_frst = n_frst;
    endtask

    function automatic int outs_vec();
        return {25'd0, wr_en_o, rd_en_o, fifo_rst_o, valid_o, busy_o, done_o, overflow_o};
    endfunction

    task automatic start_run(input int n);
        n_samples_i = CNT_W'(n);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int adc_period);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            adc_ready_i = (adc_period <= 1) ? 1'b1 : ((i % adc_period) == adc_period - 1);
            tick;
            if (done_o) seen = 1'b1;
        end
        adc_ready_i = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic finish_check(input string tag, input int words, input int ovf);
        tick;
        chk({tag, "_done_low"}, int'(done_o), 0);
        chk({tag, "_idle"}, int'(busy_o), 0);
        chk({tag, "_count"}, int'(count_o), words);
        chk({tag, "_ovf"}, int'(overflow_o), ovf);
        chk({tag, "_writes"}, n_wr - b_wr, words);
        chk({tag, "_reads"}, n_rd - b_rd, words);
        chk({tag, "_handshakes"}, n_hs - b_hs, words);
        chk({tag, "_done_pulses"}, n_done - b_done, 1);
    endtask

    initial begin
        bit seen;
        int stall, stalled_valid, rd_in_stall;

        tick;
        tick;
        chk("reset_outs", outs_vec(), 0);
        chk("reset_count", int'(count_o), 0);
        rst_i = 1'b0;
        tick;

        // Eight samples, strobe every 4th cycle, consumer always ready
        snap;
        start_run(8);
        chk("t1_clear_pulse", int'(fifo_rst_o), 1);
        chk("t1_no_wr_in_clear", int'(wr_en_o), 0);
        tick;
        chk("t1_wr_cycle2", int'(wr_en_o), 1);
        chk("t1_clear_done", int'(fifo_rst_o), 0);
        wait_done("t1", 300, 4);
        finish_check("t1", 8, 0);
        chk("t1_frst_pulses", n_frst - b_frst, 1);

        // Five samples, consumer stalls 10 cycles on the third word
        snap;
        start_run(5);
        stall = 10; stalled_valid = 0; rd_in_stall = 0; seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            adc_ready_i = 1'b1;
            if (valid_o && (n_hs - b_hs) == 2 && stall > 0) begin
                out_ready_i = 1'b0;
                stall--;
            end else begin
                out_ready_i = 1'b1;
            end
            tick;
            if (!out_ready_i && valid_o) stalled_valid++;
            if (!out_ready_i && rd_en_o) rd_in_stall++;
            if (done_o) seen = 1'b1;
        end
        adc_ready_i = 1'b0;
        out_ready_i = 1'b1;
        chk("t2_done_seen", int'(seen), 1);
        chk("t2_valid_held", stalled_valid, 10);
        chk("t2_rd_in_stall", rd_in_stall, 0);
        finish_check("t2", 5, 0);

        // Over-long request is clamped to the FIFO depth
        snap;
        start_run(2000);
        wait_done("t3", 6000, 1);
        finish_check("t3", 1024, 0);

        // FIFO reports full at 600 samples
        snap;
        start_run(700);
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            adc_ready_i = 1'b1;
            if (count_o == 11'd600) force_full = 1'b1;
            tick;
            if (done_o) seen = 1'b1;
        end
        adc_ready_i = 1'b0;
        force_full = 1'b0;
        chk("t3b_done_seen", int'(seen), 1);
        finish_check("t3b", 600, 1);
        tick;
        tick;
        chk("t3b_ovf_sticky", int'(overflow_o), 1);

        // Zero-length request
        snap;
        start_run(0);
        chk("t4_no_done_c1", int'(done_o), 0);
        chk("t4_busy_c1", int'(busy_o), 1);
        tick;
        chk("t4_done_c2", int'(done_o), 1);
        chk("t4_ovf_cleared", int'(overflow_o), 0);
        chk("t4_count", int'(count_o), 0);
        tick;
        chk("t4_writes", n_wr - b_wr, 0);
        chk("t4_reads", n_rd - b_rd, 0);
        chk("t4_frst", n_frst - b_frst, 0);

        // Abort at count 3 during capture
        snap;
        start_run(8);
        tick;
        for (int i = 0; i < 20 && count_o != 11'd3; i++) begin
            adc_ready_i = 1'b1;
            tick;
        end
        adc_ready_i = 1'b0;
        chk("t5_count_pre", int'(count_o), 3);
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk("t5_idle", int'(busy_o), 0);
        chk("t5_frst_pulse", int'(fifo_rst_o), 1);
        chk("t5_count_hold", int'(count_o), 3);
        tick;
        chk("t5_frst_end", int'(fifo_rst_o), 0);
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk("t5_idle_abort_ignored", int'(fifo_rst_o), 0);
        tick;
        chk("t5_no_done", n_done - b_done, 0);
        chk("t5_frst_pulses", n_frst - b_frst, 2);

        // Reset while presenting a word, then a normal run
        start_run(2);
        out_ready_i = 1'b0;
        for (int i = 0; i < 50 && !valid_o; i++) begin
            adc_ready_i = 1'b1;
            tick;
        end
        adc_ready_i = 1'b0;
        chk("t6_in_present", int'(valid_o), 1);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        chk("t6_rst_outs", outs_vec(), 0);
        chk("t6_rst_count", int'(count_o), 0);
        snap;
        start_run(3);
        wait_done("t6", 100, 1);
        finish_check("t6", 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Sequencer for the ADC sample FIFO (16x1024 memory wrapper). On a start command it enables FIFO writes until a programmed number of ADC samples has been stored. It then drains the FIFO one word at a time to a downstream consumer using a valid/ready handshake, and reports completion. It sits between the ADC front end, the FIFO wrapper and the output serializer.

## Interface
- DEPTH, 1024: FIFO depth in words; capture length is clamped to this.
- CNT_W, 11: sample counter width; must hold DEPTH.
- clk_i  in  1  single system clock (78 MHz); all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  capture request; sampled only in IDLE.
- abort_i  in  1  cancel any operation; highest priority after rst_i.
- n_samples_i  in  CNT_W  capture length; latched on accepted start.
- adc_ready_i  in  1  ADC sample strobe, one cycle per sample.
- fifo_full_i  in  1  FIFO full flag.
- fifo_empty_i  in  1  FIFO empty flag.
- out_ready_i  in  1  downstream accepts the word while valid_o=1.
- wr_en_o  out  1  FIFO write enable (FIFO gates it with adc_ready_i).
- rd_en_o  out  1  FIFO read request, one-cycle pulse per word.
- fifo_rst_o  out  1  one-cycle FIFO clear request.
- valid_o  out  1  FIFO output word is valid for the consumer.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- overflow_o  out  1  sticky: FIFO filled before the requested length was reached.
- count_o  out  CNT_W  samples captured in the current or last run.

## Operation
- States: IDLE, CLEAR, CAPTURE, RD, RWAIT, PRESENT, DONE.
- IDLE: on start_i, latch len = min(n_samples_i, DEPTH), clear count_o and overflow_o, and go to CLEAR. If n_samples_i=0, go directly to DONE; no write and no read occur.
- CLEAR: assert fifo_rst_o for one cycle, then go to CAPTURE.
- CAPTURE: wr_en_o=1. count_o increments on each cycle where adc_ready_i=1 and fifo_full_i=0.
  - When the increment makes count_o equal len, go to RD. wr_en_o drops in the same cycle as the transition.
  - If fifo_full_i=1 and count_o<len, set overflow_o and go to RD.
- RD: if fifo_empty_i=1, go to DONE. Otherwise pulse rd_en_o and go to RWAIT.
- RWAIT: one cycle that covers the FIFO plus wrapper output register latency. Then go to PRESENT.
- PRESENT: valid_o=1 until out_ready_i=1. On handshake, decrement the internal remaining counter (loaded with count_o on leaving CAPTURE).
  - remaining reaches 0 → DONE.
  - otherwise → RD.
- DONE: done_o=1 for one cycle, then go to IDLE. count_o and overflow_o hold until the next accepted start.
- abort_i in any non-IDLE state: go to IDLE next cycle, pulse fifo_rst_o, no done_o. count_o holds its current value. abort_i in IDLE is ignored.
- start_i outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, count_o=0, state IDLE.
- start_i at cycle 0: fifo_rst_o at cycle 1, wr_en_o high from cycle 2.
- Word handoff latency: rd_en_o at cycle t, valid_o at t+2. Minimum 3 cycles per word with out_ready_i tied high.
- valid_o is registered and stays asserted while out_ready_i=0.
- Only one FIFO read is outstanding at any time.
- adc_ready_i together with fifo_full_i in CAPTURE: the sample is not counted; overflow is set.
- Reset mid-operation returns to IDLE in one cycle. No fifo_rst_o pulse is generated by reset; the FIFO shares rst_i.

## Test plan
- n_samples_i=8, adc_ready_i every 4th cycle, out_ready_i=1 → 8 writes, 8 rd_en_o pulses, 8 valid_o handshakes, count_o=8, done_o once, overflow_o=0.
- n_samples_i=5, out_ready_i held low 10 cycles on word 3 → valid_o stays high for those cycles, no extra rd_en_o, exactly 5 handshakes.
- n_samples_i=2000 → len clamped to 1024; count_o=1024, overflow_o=0. Force fifo_full_i at count 600 on a separate run → overflow_o=1, drain of 600 words.
- n_samples_i=0 → done_o two cycles after start_i; wr_en_o, rd_en_o and fifo_rst_o never assert.
- abort_i at count 3 during CAPTURE → IDLE next cycle, fifo_rst_o pulse, no done_o, count_o=3.
- rst_i during PRESENT → all outputs 0 next cycle; a subsequent start_i runs normally.
